// File: rtl/data_mem_responder.sv
// Fixed-latency load/store responder over an internal word array, with byte-lane store merge
// and sign/zero-extended loads. Define MISALIGN_CHK_EN to fault misaligned half/word accesses.
module data_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CntW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] SpanBytes = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              wen_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              sext_q;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept;
  logic              mem_we;
  logic [31:0]       offset;
  logic [IdxW-1:0]   idx;
  logic              in_range;
  logic              misalign;
  logic              fault;
  logic [31:0]       cur_word;
  logic [31:0]       merged_word;
  logic [31:0]       load_data;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;

  assign req_ready = !rst && (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  // Address decode works on the captured request, not the live inputs.
  assign offset   = addr_q - ADDR_BASE;
  assign in_range = (addr_q >= ADDR_BASE) && (offset < SpanBytes);
  assign idx      = offset[IdxW+1:2];

`ifdef MISALIGN_CHK_EN
  assign misalign = ((size_q == 2'b01) && addr_q[0]) ||
                    ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign fault    = !in_range || (size_q == 2'b11) || misalign;
  assign cur_word = mem[idx];
  assign sel_byte = cur_word[{addr_q[1:0], 3'b000} +: 8];
  assign sel_half = cur_word[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    merged_word = cur_word;
    load_data   = cur_word;
    case (size_q)
      2'b00: begin
        merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        load_data = {{24{sext_q & sel_byte[7]}}, sel_byte};
      end
      2'b01: begin
        merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        load_data = {{16{sext_q & sel_half[15]}}, sel_half};
      end
      2'b10: begin
        merged_word = wdata_q;
        load_data   = cur_word;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_we       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWait;
          cnt_d   = CntW'(LATENCY - 1);
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_err_d   = fault;
          resp_rdata_d = (fault || wen_q) ? 32'h0 : load_data;
          mem_we       = wen_q && !fault;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d      = StIdle;
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'h0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wen_q   <= req_wen;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      size_q  <= req_size;
      sext_q  <= req_sext;
    end
  end

  // Reset in the commit cycle drops the pending store.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[idx] <= merged_word;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-array reference model checked every response cycle,
// plus directed literal expectations for each scenario.
module tb_data_mem_responder;

  localparam logic [31:0] Base  = 32'h8000_0000;
  localparam int          Depth = 1024;
  localparam int          Lat   = 2;
  localparam logic [1:0]  SzB   = 2'b00;
  localparam logic [1:0]  SzH   = 2'b01;
  localparam logic [1:0]  SzW   = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [1:0]  req_size = 2'b00;
  logic        req_sext = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  data_mem_responder #(
    .ADDR_BASE  (Base),
    .DEPTH_WORDS(Depth),
    .LATENCY    (Lat)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .req_sext  (req_sext),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests_run++;
    if (act !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp_v);
    end
  endtask

  task automatic fail_now(input string nm);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: event did not occur as required", nm);
  endtask

  // Reference model: flat byte store, little-endian, with per-byte written flags.
  logic [7:0] mb [4*Depth];
  bit         wr [4*Depth];

  function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz);
    bit e;
    e = (a < Base) || ((a - Base) >= 32'(4 * Depth)) || (sz == 2'b11);
`ifdef MISALIGN_CHK_EN
    if (sz == SzH && a[0]) e = 1'b1;
    if (sz == SzW && a[1:0] != 2'b00) e = 1'b1;
`endif
    return e;
  endfunction

  // First byte of the access: misaligned low bits are ignored (aligned down).
  function automatic int model_start(input logic [31:0] a, input logic [1:0] sz);
    int n;
    n = 1 << sz;
    return int'(a - Base) & ~(n - 1);
  endfunction

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          known;
    int          acc;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;
  bit          seen = 1'b0;
  bit          ready_next = 1'b0;

  // Compare process: every response cycle against the model's head entry.
  always @(negedge clk) begin
    if (rst) begin
      chk("req_ready_in_reset", 32'(req_ready), 32'h0);
      seen = 1'b0;
      ready_next = 1'b0;
    end else begin
      if (ready_next) begin
        chk("post_hs_resp_valid", 32'(resp_valid), 32'h0);
        chk("post_hs_req_ready", 32'(req_ready), 32'h1);
        ready_next = 1'b0;
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_resp");
        end else begin
          if (!seen) begin
            chk("latency", 32'(cyc - exp_q[0].acc), 32'(Lat));
            seen = 1'b1;
          end
          chk("resp_err", 32'(resp_err), 32'(exp_q[0].err));
          if (exp_q[0].known) chk("resp_rdata", resp_rdata, exp_q[0].rdata);
          chk("req_ready_busy", 32'(req_ready), 32'h0);
          if (resp_ready) begin
            last_rdata = resp_rdata;
            last_err   = resp_err;
            void'(exp_q.pop_front());
            seen = 1'b0;
            ready_next = 1'b1;
          end
        end
      end
    end
  end

  // Drive one request; returns one ns after the accept edge. Inputs are scrambled afterwards.
  task automatic issue(input bit wen, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input bit sx, input bit track);
    exp_t e;
    int   n;
    int   st;
    req_wen = wen; req_addr = a; req_wdata = wd; req_size = sz; req_sext = sx;
    req_valid = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      fail_now("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    e.acc   = cyc + 1;
    e.err   = model_err(a, sz);
    e.rdata = 32'h0;
    e.known = 1'b1;
    if (!e.err) begin
      st = model_start(a, sz);
      for (int i = 0; i < (1 << sz); i++) begin
        if (wen) begin
          if (track) begin
            mb[st + i] = 8'(wd >> (8 * i));
            wr[st + i] = 1'b1;
          end
        end else begin
          e.rdata = e.rdata | (32'(mb[st + i]) << (8 * i));
          if (!wr[st + i]) e.known = 1'b0;
        end
      end
      if (!wen && sx && sz == SzB && e.rdata[7])  e.rdata = e.rdata | 32'hFFFF_FF00;
      if (!wen && sx && sz == SzH && e.rdata[15]) e.rdata = e.rdata | 32'hFFFF_0000;
    end
    if (track) exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wen = ~wen; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_0BAD;
    req_size = ~sz; req_sext = ~sx;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      fail_now("resp_timeout");
      exp_q.delete();
    end
  endtask

  task automatic txn(input bit wen, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] sz, input bit sx);
    issue(wen, a, wd, sz, sx, 1'b1);
    wait_done();
  endtask

  task automatic ld(input string nm, input logic [31:0] a, input logic [1:0] sz, input bit sx,
                    input logic [31:0] exp_d, input bit exp_e);
    txn(1'b0, a, 32'h0, sz, sx);
    chk({nm, "_rdata"}, last_rdata, exp_d);
    chk({nm, "_err"}, 32'(last_err), 32'(exp_e));
  endtask

  task automatic st(input string nm, input logic [31:0] a, input logic [31:0] wd,
                    input logic [1:0] sz, input bit exp_e);
    txn(1'b1, a, wd, sz, 1'b0);
    chk({nm, "_rdata"}, last_rdata, 32'h0);
    chk({nm, "_err"}, 32'(last_err), 32'(exp_e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int          n;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h1);

    // Word store then load.
    st("t1_st", Base, 32'hDEAD_BEEF, SzW, 1'b0);
    ld("t1_ld", Base, SzW, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // Byte merge and extension.
    st("t2_st_w", Base + 4, 32'h1122_3344, SzW, 1'b0);
    st("t2_st_b", Base + 5, 32'hFFFF_FF80, SzB, 1'b0);
    ld("t2_word", Base + 4, SzW, 1'b0, 32'h1122_8044, 1'b0);
    ld("t2_b_sext", Base + 5, SzB, 1'b1, 32'hFFFF_FF80, 1'b0);
    ld("t2_b_zext", Base + 5, SzB, 1'b0, 32'h0000_0080, 1'b0);
    ld("t2_b_lane3", Base + 7, SzB, 1'b1, 32'h0000_0011, 1'b0);

    // Half merge and extension.
    st("t3_st_w", Base + 8, 32'h0, SzW, 1'b0);
    st("t3_st_h", Base + 10, 32'h1234_ABCD, SzH, 1'b0);
    ld("t3_word", Base + 8, SzW, 1'b0, 32'hABCD_0000, 1'b0);
    ld("t3_h_sext", Base + 10, SzH, 1'b1, 32'hFFFF_ABCD, 1'b0);
    ld("t3_h_zext", Base + 10, SzH, 1'b0, 32'h0000_ABCD, 1'b0);
    ld("t3_h_low", Base + 8, SzH, 1'b1, 32'h0000_0000, 1'b0);

    // Backpressure: response held stable while resp_ready is low.
    resp_ready = 1'b0;
    issue(1'b0, Base + 4, 32'h0, SzW, 1'b0, 1'b1);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) fail_now("hold_resp_never_valid");
    held = resp_rdata;
    chk("hold_first_rdata", held, 32'h1122_8044);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'h1);
      chk("hold_rdata", resp_rdata, held);
      chk("hold_req_ready", 32'(req_ready), 32'h0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    wait_done();
    chk("hold_last_rdata", last_rdata, 32'h1122_8044);

    // Faults leave memory untouched.
    ld("t5_below", 32'h7FFF_FFFC, SzW, 1'b0, 32'h0, 1'b1);
    ld("t5_above", Base + 32'(4 * Depth), SzW, 1'b0, 32'h0, 1'b1);
    ld("t5_size3", Base, 2'b11, 1'b0, 32'h0, 1'b1);
    st("t5_st_size3", Base, 32'h0, 2'b11, 1'b1);
    st("t5_st_above", Base + 32'(4 * Depth), 32'h0, SzW, 1'b1);
    ld("t5_after", Base, SzW, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // Reset one cycle after accepting a store aborts it.
    issue(1'b1, Base + 4, 32'h5555_5555, SzW, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_resp", 32'(resp_valid), 32'h0);
    ld("t6_kept", Base + 4, SzW, 1'b0, 32'h1122_8044, 1'b0);

    // Misaligned word store and half load.
    st("t7_pre", Base + 12, 32'hCAFE_F00D, SzW, 1'b0);
`ifdef MISALIGN_CHK_EN
    st("t7_st_mis", Base + 14, 32'h1234_5678, SzW, 1'b1);
    ld("t7_word", Base + 12, SzW, 1'b0, 32'hCAFE_F00D, 1'b0);
    ld("t7_h_mis", Base + 9, SzH, 1'b1, 32'h0, 1'b1);
`else
    st("t7_st_mis", Base + 14, 32'h1234_5678, SzW, 1'b0);
    ld("t7_word", Base + 12, SzW, 1'b0, 32'h1234_5678, 1'b0);
    ld("t7_h_mis", Base + 11, SzH, 1'b1, 32'hFFFF_ABCD, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
